// File: rtl/fsm_call_responder.sv
// Callee side of the FSM call/return handshake: one outstanding call, two-exit function, registered outputs.
// Optional build macro FSM_CALL_COUNT_EN adds a saturating return-handshake counter (call_count).
module fsm_call_responder #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CMP_VALUE = 0,
   parameter int unsigned K0        = 2,
   parameter int unsigned K1        = 3,
   parameter int unsigned EVAL_CYC  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             call_valid,
   input  logic [WIDTH-1:0] call_arg,
   output logic             call_ready,
   output logic             ret_valid,
   input  logic             ret_ready,
   output logic [WIDTH-1:0] ret_value,
   output logic             ret_path,
   output logic             busy
`ifdef FSM_CALL_COUNT_EN
   ,
   output logic [15:0]      call_count
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EVAL_CYC - 1);
   localparam logic [WIDTH-1:0] CMP_W    = WIDTH'(CMP_VALUE);
   localparam logic [WIDTH-1:0] K0_W     = WIDTH'(K0);
   localparam logic [WIDTH-1:0] K1_W     = WIDTH'(K1);

   typedef enum logic [7:0] {
      ST_IDLE   = 8'd0,
      ST_EVAL   = 8'd1,
      ST_RETURN = 8'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   arg_q;

   // Call/evaluate/return sequencer; every output is a register written here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         arg_q      <= '0;
         call_ready <= 1'b1;
         ret_valid  <= 1'b0;
         ret_value  <= '0;
         ret_path   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               call_ready <= 1'b1;
               ret_valid  <= 1'b0;
               busy       <= 1'b0;
               if (call_valid && call_ready) begin
                  arg_q      <= call_arg;
                  cnt        <= CNT_INIT;
                  call_ready <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (cnt == '0) begin
                  if (arg_q == CMP_W) begin
                     ret_value <= arg_q + K0_W;
                     ret_path  <= 1'b0;
                  end else begin
                     ret_value <= arg_q + K1_W;
                     ret_path  <= 1'b1;
                  end
                  ret_valid <= 1'b1;
                  state     <= ST_RETURN;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_RETURN: begin
               // Result stays parked until the caller takes it; call_ready rises with IDLE.
               if (ret_ready) begin
                  ret_valid  <= 1'b0;
                  call_ready <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               state      <= ST_IDLE;
               cnt        <= '0;
               arg_q      <= '0;
               call_ready <= 1'b1;
               ret_valid  <= 1'b0;
               ret_value  <= '0;
               ret_path   <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

`ifdef FSM_CALL_COUNT_EN
   // Completed-return counter, saturating at all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         call_count <= '0;
      end else if (ret_valid && ret_ready) begin
         if (call_count != 16'hFFFF) begin
            call_count <= call_count + 16'd1;
         end
         $display("fsm_call_responder: result %0h path %0d", ret_value, ret_path);
      end
   end
`endif

endmodule

// File: tb/tb_fsm_call_responder.sv
// Scoreboarded bench for fsm_call_responder: EVAL_CYC=1 instance on the queue, EVAL_CYC=4 instance directed.
module tb_fsm_call_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, call_valid, ret_ready;
   logic [31:0] call_arg;
   logic        call_ready, ret_valid, ret_path, busy;
   logic [31:0] ret_value;

   logic        reset1, call_valid1, ret_ready1;
   logic [31:0] call_arg1;
   logic        call_ready1, ret_valid1, ret_path1, busy1;
   logic [31:0] ret_value1;
`ifdef FSM_CALL_COUNT_EN
   logic [15:0] call_count, call_count1;
`endif

   fsm_call_responder #(.EVAL_CYC(1)) dut (
      .clk(clk), .reset(reset), .call_valid(call_valid), .call_arg(call_arg),
      .call_ready(call_ready), .ret_valid(ret_valid), .ret_ready(ret_ready),
      .ret_value(ret_value), .ret_path(ret_path), .busy(busy)
`ifdef FSM_CALL_COUNT_EN
      , .call_count(call_count)
`endif
   );

   fsm_call_responder #(.EVAL_CYC(4)) dut4 (
      .clk(clk), .reset(reset1), .call_valid(call_valid1), .call_arg(call_arg1),
      .call_ready(call_ready1), .ret_valid(ret_valid1), .ret_ready(ret_ready1),
      .ret_value(ret_value1), .ret_path(ret_path1), .busy(busy1)
`ifdef FSM_CALL_COUNT_EN
      , .call_count(call_count1)
`endif
   );

   typedef struct packed {
      logic [31:0] v;
      logic        p;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every return handshake pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (ret_valid === 1'b1 && ret_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got value %0h with nothing expected", ret_value);
         end else begin
            e = sb_q.pop_front();
            chk("sb_value", ret_value, e.v);
            chk("sb_path", 32'(ret_path), 32'(e.p));
         end
      end
   end

   // Present a call on the EVAL_CYC=1 instance; returns at the negedge after the accept edge.
   task automatic do_call(input logic [31:0] arg, input logic [31:0] ev, input logic ep);
      sb_q.push_back('{v: ev, p: ep});
      @(posedge clk); #1;
      call_valid = 1'b1;
      call_arg   = arg;
      @(negedge clk);
      chk("pre_ready", 32'(call_ready), 32'd1);
      @(posedge clk); #1;
      call_valid = 1'b0;
      @(negedge clk);
      chk("eval_busy", 32'(busy), 32'd1);
      chk("eval_ready", 32'(call_ready), 32'd0);
      chk("eval_valid", 32'(ret_valid), 32'd0);
   endtask

   task automatic do_call_fast(input logic [31:0] arg, input logic [31:0] ev, input logic ep);
      do_call(arg, ev, ep);
      @(negedge clk);
      chk("ret_valid_up", 32'(ret_valid), 32'd1);
      @(negedge clk);
      chk("ret_valid_pulse", 32'(ret_valid), 32'd0);
      chk("post_ready", 32'(call_ready), 32'd1);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1; call_valid = 1'b0; call_arg = '0; ret_ready = 1'b1;
      reset1 = 1'b1; call_valid1 = 1'b0; call_arg1 = '0; ret_ready1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      reset1 = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(call_ready), 32'd1);
         chk("idle_valid", 32'(ret_valid), 32'd0);
         chk("idle_value", ret_value, 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      do_call_fast(32'd10, 32'd13, 1'b1);
      do_call_fast(32'd0, 32'd2, 1'b0);
      do_call_fast(32'hFFFF_FFFF, 32'h2, 1'b1);

      // Caller stalls the return; a competing call must be dropped.
      @(posedge clk); #1;
      ret_ready = 1'b0;
      do_call(32'd5, 32'd8, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            call_valid = 1'b1;
            call_arg   = 32'd99;
         end
         if (i == 15) call_valid = 1'b0;
         @(negedge clk);
         chk("stall_valid", 32'(ret_valid), 32'd1);
         chk("stall_value", ret_value, 32'd8);
         chk("stall_ready", 32'(call_ready), 32'd0);
      end
      @(posedge clk); #1;
      ret_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("release_valid", 32'(ret_valid), 32'd0);
      chk("release_ready", 32'(call_ready), 32'd1);
      chk("release_busy", 32'(busy), 32'd0);
      chk("idle_hold_value", ret_value, 32'd8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("dropped_call_valid", 32'(ret_valid), 32'd0);
         chk("dropped_call_busy", 32'(busy), 32'd0);
      end

      // EVAL_CYC=4: result appears four edges after accept.
      @(posedge clk); #1;
      call_valid1 = 1'b1;
      call_arg1   = 32'd7;
      @(posedge clk); #1;
      call_valid1 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("lat4_valid", 32'(ret_valid1), 32'(k == 4));
      end
      chk("lat4_value", ret_value1, 32'd10);
      chk("lat4_path", 32'(ret_path1), 32'd1);
      @(negedge clk);
      chk("lat4_done", 32'(ret_valid1), 32'd0);

      // EVAL_CYC=4: reset two cycles after accept abandons the call.
      @(posedge clk); #1;
      call_valid1 = 1'b1;
      call_arg1   = 32'd20;
      @(posedge clk); #1;
      call_valid1 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset1 = 1'b1;
      @(posedge clk); #1;
      reset1 = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_ready", 32'(call_ready1), 32'd1);
      chk("abort_value", ret_value1, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 32'(ret_valid1), 32'd0);
      end

`ifdef FSM_CALL_COUNT_EN
      chk("count_after_calls", 32'(call_count), 32'd4);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("count_after_reset", 32'(call_count), 32'd0);
`endif

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
